fetch_buffer: RTL and testbench
===============================

FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 Parameter DEPTH, 8, buffer entries; power of two, 4..64.
REQ-002 Parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-003 Parameter ISSUE_W, 2, instruction slots presented per cycle; 1 or 2.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 en  input  1  global enable; low freezes all state and holds all outputs.
REQ-007 mem_req  output  1  fetch request to instruction memory.
REQ-008 mem_addr  output  32  word-aligned fetch address.
REQ-009 mem_ack  input  1  one-cycle response strobe carrying mem_rdata.
REQ-010 mem_rdata  input  32  fetched instruction word.
REQ-011 flush  input  1  discard buffer and in-flight data; refetch from redirect_pc.
REQ-012 redirect_pc  input  32  new fetch address, sampled when flush is high.
REQ-013 pop_count  input  2  instructions consumed this cycle (0..ISSUE_W).
REQ-014 instr0, instr1  output  32 each  oldest and second-oldest entries.
REQ-015 pc0  output  32  address of instr0.
REQ-016 valid0, valid1  output  1 each  instr0/instr1 hold real entries.
REQ-017 count  output  $clog2(DEPTH)+1  occupied entries.
REQ-018 empty  output  1  count == 0.

Function
REQ-019 Buffer SHALL be a circular FIFO with read/write pointers wrapping modulo DEPTH.
REQ-020 Request FSM SHALL have states IDLE, WAIT, DRAIN.
REQ-021 IDLE -> WAIT when count + pending pushes < DEPTH; mem_req=1, mem_addr=fetch_pc.
REQ-022 In WAIT, mem_req and mem_addr SHALL stay stable until mem_ack; at most one request outstanding.
REQ-023 WAIT + mem_ack, no flush: push mem_rdata with pc=fetch_pc, fetch_pc += 4, -> IDLE.
REQ-024 Pushed word SHALL appear on outputs the cycle after mem_ack (latency 1); not poppable in the ack cycle.
REQ-025 Pops SHALL remove min(pop_count, count, ISSUE_W) entries from the head; push and pop in the same cycle both apply.
REQ-026 When full (count == DEPTH), no new request SHALL issue; an outstanding ack is always accepted because FSM reserves its slot.
REQ-027 valid1 and instr1 SHALL be tied to 0 when ISSUE_W == 1.
REQ-028 Invalid slots SHALL output instr = 32'd0; pc0 = fetch_pc when empty.
REQ-029 flush SHALL clear count/pointers next cycle and load fetch_pc = redirect_pc; flush overrides same-cycle pop and push.
REQ-030 flush in WAIT without ack -> DRAIN: mem_req held until ack, that word discarded, then -> IDLE.
REQ-031 flush with same-cycle mem_ack: word discarded, -> IDLE.
REQ-032 flush in DRAIN: redirect_pc replaces fetch_pc; remain DRAIN.
REQ-033 Sum of pushes minus pops SHALL never drive count above DEPTH or below 0.

Reset
REQ-034 rst high SHALL asynchronously force: FSM=IDLE, mem_req=0, mem_addr=RESET_PC, fetch_pc=RESET_PC, pointers=0, count=0, empty=1, valid0=valid1=0, instr0=instr1=0, pc0=RESET_PC.
REQ-035 First mem_req SHALL assert on the first enabled edge after rst deasserts.
REQ-036 rst during WAIT/DRAIN SHALL abandon the request; a later stray mem_ack with FSM in IDLE SHALL be ignored.

Configuration
REQ-037 Macro FETCH_BUFFER_PERF_EN defined: adds output starve_cycles (32) counting enabled cycles with empty=1 and no flush, saturating at 32'hFFFF_FFFF, reset 0.
REQ-038 Macro undefined: port and counter SHALL not exist; all other behaviour identical.

Verification
REQ-039 Reset, ack every 3rd cycle, pop_count=0, DEPTH=8 -> 8 words at PC 0..0x1C buffered, count=8, mem_req stays 0 thereafter.
REQ-040 Full buffer, pop_count=2 for one cycle -> count=6, next mem_addr=0x20, in-order words at output.
REQ-041 flush with redirect_pc=0x100 while in WAIT, ack 2 cycles later -> acked word dropped, next mem_addr=0x100, empty=1 until that ack.
REQ-042 flush and mem_ack same cycle -> count=0, word dropped, next request at redirect_pc.
REQ-043 count=1, pop_count=2 with same-cycle ack -> one popped, count=1, valid1=0 next cycle.
REQ-044 FETCH_BUFFER_PERF_EN defined, 5 starved cycles -> starve_cycles=5; rst -> 0.

Source files
------------

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: a single-outstanding-request fetch FSM feeding a circular FIFO.
// Optional feature: define FETCH_BUFFER_PERF_EN to add the saturating starve_cycles counter.
module fetch_buffer #(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ISSUE_W  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  output logic                       mem_req,
  output logic [31:0]                mem_addr,
  input  logic                       mem_ack,
  input  logic [31:0]                mem_rdata,
  input  logic                       flush,
  input  logic [31:0]                redirect_pc,
  input  logic [1:0]                 pop_count,
  output logic [31:0]                instr0,
  output logic [31:0]                instr1,
  output logic [31:0]                pc0,
  output logic                       valid0,
  output logic                       valid1,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
`ifdef FETCH_BUFFER_PERF_EN
  ,
  output logic [31:0]                starve_cycles
`endif
);

  localparam int            AW   = $clog2(DEPTH);
  localparam int            CW   = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

  state_t          state_q, state_d;
  logic            mem_req_q, mem_req_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     mem_q [DEPTH];
  logic            push;
  logic [1:0]      pop_n;
  logic [31:0]     redirect_al;

  assign redirect_al = redirect_pc & ~32'h3;

  // Pops are clamped to the issue width and to what is already resident.
  always_comb begin
    pop_n = pop_count;
    if (pop_n > 2'(ISSUE_W)) pop_n = 2'(ISSUE_W);
    if (CW'(pop_n) > count_q) pop_n = count_q[1:0];
  end

  // A request only issues from IDLE with a free slot, so its ack always has room.
  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    fetch_pc_d = fetch_pc_q;
    push       = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush) begin
          fetch_pc_d = redirect_al;
        end else if (count_q != FULL) begin
          state_d    = WAIT;
          mem_req_d  = 1'b1;
          mem_addr_d = fetch_pc_q;
        end
      end
      WAIT: begin
        if (flush) begin
          fetch_pc_d = redirect_al;
          if (mem_ack) begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
          end else begin
            state_d = DRAIN;
          end
        end else if (mem_ack) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = IDLE;
          mem_req_d  = 1'b0;
        end
      end
      DRAIN: begin
        if (flush) fetch_pc_d = redirect_al;
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    rptr_d  = rptr_q + AW'(pop_n);
    wptr_d  = wptr_q + AW'(push);
    count_d = count_q - CW'(pop_n) + CW'(push);
    if (flush) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      rptr_q     <= '0;
      wptr_q     <= '0;
      count_q    <= '0;
    end else if (en) begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      fetch_pc_q <= fetch_pc_d;
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: every read is gated by the occupancy count.
  always_ff @(posedge clk) begin
    if (en && push) mem_q[wptr_q] <= mem_rdata;
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign count    = count_q;
  assign empty    = (count_q == '0);
  assign valid0   = !empty;
  assign instr0   = valid0 ? mem_q[rptr_q] : 32'd0;
  // Resident words are always the contiguous run ending just below fetch_pc.
  assign pc0      = fetch_pc_q - 32'({count_q, 2'b00});

  if (ISSUE_W > 1) begin : g_slot1
    assign valid1 = (count_q > CW'(1));
    assign instr1 = valid1 ? mem_q[rptr_q + AW'(1)] : 32'd0;
  end else begin : g_no_slot1
    assign valid1 = 1'b0;
    assign instr1 = 32'd0;
  end

`ifdef FETCH_BUFFER_PERF_EN
  logic [31:0] starve_q, starve_d;

  always_comb begin
    starve_d = starve_q;
    if (empty && !flush && (starve_q != 32'hFFFF_FFFF)) starve_d = starve_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     starve_q <= '0;
    else if (en) starve_q <= starve_d;
  end

  assign starve_cycles = starve_q;
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: directed table, hand-written flush/ack corner sequences,
// and a randomized run against a queue-based reference model.
module tb_fetch_buffer;
  localparam int          DEPTH    = 8;
  localparam int          ISSUE_W  = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          CW       = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst, en, mem_req, mem_ack, flush, valid0, valid1, empty;
  logic [31:0]   mem_addr, mem_rdata, redirect_pc, instr0, instr1, pc0;
  logic [1:0]    pop_count;
  logic [CW-1:0] count;
`ifdef FETCH_BUFFER_PERF_EN
  logic [31:0]   starve_cycles;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .ISSUE_W(ISSUE_W)) dut (
    .clk(clk), .rst(rst), .en(en), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .flush(flush), .redirect_pc(redirect_pc),
    .pop_count(pop_count), .instr0(instr0), .instr1(instr1), .pc0(pc0),
    .valid0(valid0), .valid1(valid1), .count(count), .empty(empty)
`ifdef FETCH_BUFFER_PERF_EN
    , .starve_cycles(starve_cycles)
`endif
  );

  typedef struct {
    int          op;      // 0: fetch one word at arg, 1: pop arg entries for one cycle
    logic [31:0] arg;
    int          ecount;
    logic [31:0] epc0;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] w;
  } ent_t;

  vec_t        tbl [15];
  ent_t        mq [$];
  logic [31:0] m_fpc, m_addr;
  bit          m_outs, m_drop;

  function automatic logic [31:0] wd(input logic [31:0] pc);
    return pc ^ 32'hA5C3_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    en = 1'b1; flush = 1'b0; pop_count = 2'd0; mem_ack = 1'b0;
    mem_rdata = 32'd0; redirect_pc = 32'd0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!mem_req && n < 20) begin
      step();
      n++;
    end
    chk("req_wait", 32'(mem_req), 32'd1);
  endtask

  task automatic fetch(input logic [31:0] addr);
    wait_req();
    chk("fetch_addr", mem_addr, addr);
    mem_ack = 1'b1; mem_rdata = wd(addr);
    step();
    mem_ack = 1'b0;
  endtask

  task automatic check_state(input int ec, input logic [31:0] epc);
    chk("count", 32'(count), ec);
    chk("pc0", pc0, epc);
    chk("valid0", 32'(valid0), 32'(ec > 0));
    chk("instr0", instr0, (ec > 0) ? wd(epc) : 32'd0);
    chk("valid1", 32'(valid1), 32'(ec > 1));
    chk("instr1", instr1, (ec > 1) ? wd(epc + 32'd4) : 32'd0);
  endtask

  task automatic model_reset();
    mq.delete();
    m_fpc = RESET_PC; m_addr = RESET_PC; m_outs = 0; m_drop = 0;
  endtask

  task automatic model_step();
    int sz, n;
    bit ack, outs0;
    if (rst) begin
      model_reset();
    end else if (en) begin
      sz = mq.size(); outs0 = m_outs; ack = m_outs && mem_ack;
      if (flush) begin
        mq.delete();
        m_fpc = redirect_pc;
        if (ack) begin m_outs = 0; m_drop = 0; end
        else if (m_outs) m_drop = 1;
      end else begin
        n = pop_count;
        if (n > ISSUE_W) n = ISSUE_W;
        if (n > sz) n = sz;
        repeat (n) void'(mq.pop_front());
        if (ack) begin
          if (!m_drop) begin
            mq.push_back('{m_fpc, mem_rdata});
            m_fpc = m_fpc + 32'd4;
          end
          m_outs = 0; m_drop = 0;
        end else if (!outs0 && sz < DEPTH) begin
          m_outs = 1; m_addr = m_fpc;
        end
      end
    end
  endtask

  task automatic cmp_model();
    int sz = mq.size();
    chk("rnd_mem_req", 32'(mem_req), 32'(m_outs));
    if (m_outs) chk("rnd_mem_addr", mem_addr, m_addr);
    chk("rnd_count", 32'(count), sz);
    chk("rnd_empty", 32'(empty), 32'(sz == 0));
    chk("rnd_pc0", pc0, (sz > 0) ? mq[0].pc : m_fpc);
    chk("rnd_instr0", instr0, (sz > 0) ? mq[0].w : 32'd0);
    chk("rnd_valid1", 32'(valid1), 32'(sz > 1));
    chk("rnd_instr1", instr1, (sz > 1) ? mq[1].w : 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, RESET_PC);
    chk("rst_empty", 32'(empty), 32'd1);
    check_state(0, RESET_PC);

    // Fill to full, pop, refill, clamped pops.
    for (int i = 0; i < 8; i++) tbl[i] = '{0, 32'(4 * i), i + 1, 32'h0};
    tbl[8]  = '{1, 32'd2, 6, 32'h08};
    tbl[9]  = '{0, 32'h20, 7, 32'h08};
    tbl[10] = '{1, 32'd1, 6, 32'h0C};
    tbl[11] = '{1, 32'd3, 4, 32'h14};
    tbl[12] = '{1, 32'd2, 2, 32'h1C};
    tbl[13] = '{1, 32'd3, 0, 32'h24};
    tbl[14] = '{0, 32'h24, 1, 32'h24};

    do_reset();
    step();
    chk("first_req", 32'(mem_req), 32'd1);
    chk("first_addr", mem_addr, RESET_PC);
    for (int i = 0; i < 15; i++) begin
      if (tbl[i].op == 0) fetch(tbl[i].arg);
      else begin
        pop_count = tbl[i].arg[1:0];
        step();
        pop_count = 2'd0;
      end
      check_state(tbl[i].ecount, tbl[i].epc0);
      if (i == 7) begin
        for (int k = 0; k < 6; k++) begin
          step();
          chk("full_no_req", 32'(mem_req), 32'd0);
        end
        chk("full_count", 32'(count), DEPTH);
      end
    end

    // Flush while waiting: acked word dropped, refetch at redirect.
    do_reset();
    wait_req();
    flush = 1'b1; redirect_pc = 32'h100;
    step();
    flush = 1'b0;
    chk("drain_req_held", 32'(mem_req), 32'd1);
    chk("drain_addr_held", mem_addr, 32'h0);
    check_state(0, 32'h100);
    step();
    chk("drain_empty", 32'(empty), 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_ack = 1'b0;
    chk("drain_done_req", 32'(mem_req), 32'd0);
    chk("drain_dropped", 32'(empty), 32'd1);
    fetch(32'h100);
    check_state(1, 32'h100);

    // Async reset mid-request, then a stray ack while idle.
    step();
    chk("pre_rst_req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_req", 32'(mem_req), 32'd0);
    chk("async_rst_addr", mem_addr, RESET_PC);
    check_state(0, RESET_PC);
    step();
    rst = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    step();
    mem_ack = 1'b0;
    chk("stray_ack_ignored", 32'(count), 32'd0);
    chk("post_rst_req", 32'(mem_req), 32'd1);

    // Flush with same-cycle ack.
    do_reset();
    fetch(32'h0);
    fetch(32'h4);
    wait_req();
    chk("fa_addr", mem_addr, 32'h8);
    flush = 1'b1; redirect_pc = 32'h200; mem_ack = 1'b1; mem_rdata = wd(32'h8);
    step();
    idle();
    chk("fa_req", 32'(mem_req), 32'd0);
    check_state(0, 32'h200);
    wait_req();
    chk("fa_redirect_addr", mem_addr, 32'h200);

    // Over-pop with same-cycle push: the new word is not poppable yet.
    do_reset();
    fetch(32'h0);
    wait_req();
    pop_count = 2'd2; mem_ack = 1'b1; mem_rdata = wd(32'h4);
    step();
    idle();
    check_state(1, 32'h4);

`ifdef FETCH_BUFFER_PERF_EN
    do_reset();
    for (int k = 0; k < 5; k++) step();
    chk("starve_5", starve_cycles, 32'd5);
    rst = 1'b1;
    #1;
    chk("starve_rst", starve_cycles, 32'd0);
    step();
    rst = 1'b0;
`endif

    // Randomized run against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      cmp_model();
      rst         = ($urandom_range(0, 199) == 0);
      en          = ($urandom_range(0, 9) != 0);
      flush       = ($urandom_range(0, 29) == 0);
      redirect_pc = $urandom & 32'hFFFF_FFFC;
      if (((c / 400) % 2) == 0) pop_count = ($urandom_range(0, 9) < 2) ? 2'($urandom_range(1, 3)) : 2'd0;
      else                      pop_count = 2'($urandom_range(0, 3));
      mem_ack     = m_outs ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      mem_rdata   = $urandom;
      @(posedge clk);
      model_step();
      @(negedge clk);
    end
    cmp_model();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
